key_buffer: RTL and testbench
=============================

// Module: key_buffer
// PURPOSE
// - Parametrised successor to the single-latch keyboard path: queues translated keystrokes in a FIFO.
// - Adds typematic auto-repeat and presents Apple II $C000/$C010 strobe semantics to the apple_2e core.
// - Sits between the keycode/modifier translation logic and the CPU keyboard port.
// - Runs on Clock_14Mhz; no keystroke is lost while the CPU is slow to service $C010.
// PARAMETERS
// - DEPTH         8      FIFO entries; power of two, >=2
// - DATA_W        7      ASCII code width (Apple II uses 7)
// - TICK_DIV      14318  Clock_14Mhz cycles per 1 ms repeat tick
// - REPEAT_DELAY  534    ms from key-down to first repeat
// - REPEAT_PERIOD 67     ms between repeats (~15 Hz)
// PORTS
// - Clock_14Mhz   in   1       system clock; all state on rising edge
// - reset         in   1       synchronous, active-high
// - key_down      in   1       level: a non-modifier key is held (already synchronised)
// - ascii_in      in   DATA_W  translated code of held key; valid while key_down=1
// - clear_strobe  in   1       1-cycle pulse: CPU access to $C010
// - kbd_data      out  8       {strobe, ascii}: CPU read value of $C000
// - any_key_down  out  1       key_down registered; read as bit 7 of $C010
// - fifo_count    out  $clog2(DEPTH)+1  entries waiting (excludes the presented key)
// - overflow      out  1       sticky: a key was dropped because the FIFO was full
// BEHAVIOUR
// - Reset: kbd_data=8'h00, any_key_down=0, fifo_count=0, overflow=0.
//   Reset also sets repeat FSM=IDLE, tick prescaler=0, FIFO empty.
//   Reset mid-operation discards queued keys and any pending repeat.
// - Reset has priority over every other input.
// - Key press edge:
//   - key_down 0->1, or ascii_in changes while key_down=1 (rollover), pushes ascii_in.
//   - Push takes effect in cycle t; fifo_count updates at t+1.
// - Presentation:
//   - When strobe==0 and FIFO non-empty, pop the head into kbd_data[6:0] and set strobe (bit 7).
//   - Empty FIFO with strobe==0 at push cycle t: strobe=1, kbd_data valid at t+2.
// - clear_strobe:
//   - Clears bit 7 at the next edge; kbd_data[6:0] holds the last code.
//   - The next queued key loads no earlier than one cycle after the clear takes effect.
//   - clear_strobe while strobe==0 has no effect.
// - Simultaneous events:
//   - Push and pop in the same cycle: count unchanged, order preserved.
//   - Push into a full FIFO is dropped and sets overflow, even if a pop occurs the same cycle.
//   - overflow clears only on reset.
// - Repeat FSM (states IDLE, DELAY, REPEAT; ms counter driven by a TICK_DIV prescaler):
//   - IDLE -> DELAY on a press edge; ms counter=0.
//   - DELAY -> REPEAT when the counter reaches REPEAT_DELAY; push ascii_in; counter=0.
//   - REPEAT: push every REPEAT_PERIOD ms.
//   - Any state -> IDLE when key_down=0.
//   - Rollover: restart DELAY with the new code.
//   - Repeat pushes obey the same full/overflow rule.
// - Wrap-around: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - Full/empty is derived from count, never from pointer equality.
// - any_key_down = key_down delayed by one cycle.
// STRUCTURE
// - Package apple2_kbd_pkg: typedef enum logic[1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t.
//   - Also holds localparams for default DEPTH, TICK_DIV and delay/period in ms.
// - Sub-module key_fifo #(DEPTH, DATA_W):
//   - Synchronous FIFO with push, pop, dout, count, full, empty.
//   - Register-array storage; dout is the head combinationally.
// - key_buffer owns edge detect, the prescaler/ms counter, the repeat FSM, the strobe register and overflow.
// TESTING
// - Bench uses TICK_DIV=4, REPEAT_DELAY=5, REPEAT_PERIOD=2.
// - Single key: key_down=1, ascii_in=7'h41 at cycle 10 -> kbd_data=8'hC1 at cycle 12.
//   - clear_strobe at 20 -> kbd_data=8'h41 at 21.
// - Queueing: press 'A','B','C' while strobe set -> fifo_count=2.
//   - Each clear_strobe presents B (8'hC2), then C (8'hC3); fifo_count ends at 0.
// - Overflow (DEPTH=4): 6 presses with no clear -> 1 presented, fifo_count=4, overflow=1.
//   - FIFO contents are keys 2-5 in order.
// - Auto-repeat: hold 7'h20 -> first push at 5 ms (20 cycles after press edge), then every 8 cycles.
//   - Release -> no further pushes.
// - Simultaneous: clear_strobe on the same cycle as a push with FIFO full -> push dropped, overflow=1, count stays DEPTH-1 after pop.
// - Reset mid-repeat with 3 queued -> all outputs 0 next cycle; no push until a new press edge.

Source files
------------

// File: rtl/apple2_kbd_pkg.sv
// Shared types and default timing for the Apple II keyboard buffer.
package apple2_kbd_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  localparam int DEF_DEPTH         = 8;
  localparam int DEF_DATA_W        = 7;
  localparam int DEF_TICK_DIV      = 14318;
  localparam int DEF_REPEAT_DELAY  = 534;
  localparam int DEF_REPEAT_PERIOD = 67;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for translated keycodes; head is visible combinationally.
module key_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  // Occupancy comes from count so a full FIFO is never mistaken for empty.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_buffer.sv
// Keystroke queue with typematic repeat, presenting $C000/$C010 strobe semantics.
// state      | meaning
// RPT_IDLE   | no key held, or waiting for a press edge
// RPT_DELAY  | key held, counting ms until the first repeat
// RPT_REPEAT | key held, pushing the code every repeat period
module key_buffer
  import apple2_kbd_pkg::*;
#(
  parameter int DEPTH         = DEF_DEPTH,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                   Clock_14Mhz,
  input  logic                   reset,
  input  logic                   key_down,
  input  logic [DATA_W-1:0]      ascii_in,
  input  logic                   clear_strobe,
  output logic [7:0]             kbd_data,
  output logic                   any_key_down,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int MS_W    = $clog2(MS_MAX + 1);

  rpt_state_t         state;
  logic [PRESC_W-1:0] presc;
  logic [MS_W-1:0]    ms_cnt;
  logic [DATA_W-1:0]  ascii_q;
  logic [DATA_W-1:0]  kbd_ascii;
  logic               strobe;

  logic               press_edge;
  logic               tick;
  logic               rpt_fire;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;

  // A code change while the key stays down is a rollover and counts as a new press.
  assign press_edge = key_down && (!any_key_down || (ascii_in != ascii_q));
  assign tick       = (presc == PRESC_W'(TICK_DIV - 1));

  always_comb begin
    rpt_fire = 1'b0;
    if (key_down && tick) begin
      case (state)
        RPT_DELAY:  rpt_fire = (ms_cnt == MS_W'(REPEAT_DELAY - 1));
        RPT_REPEAT: rpt_fire = (ms_cnt == MS_W'(REPEAT_PERIOD - 1));
        default:    rpt_fire = 1'b0;
      endcase
    end
  end

  assign push = press_edge || rpt_fire;
  assign pop  = !strobe && !fifo_empty;

  key_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (Clock_14Mhz),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (ascii_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clock_14Mhz) begin
    if (reset) begin
      any_key_down <= 1'b0;
      ascii_q      <= '0;
    end else begin
      any_key_down <= key_down;
      ascii_q      <= ascii_in;
    end
  end

  // The prescaler only runs while a key is held so the first repeat lands a fixed time after the press.
  always_ff @(posedge Clock_14Mhz) begin
    if (reset || !key_down) begin
      state  <= RPT_IDLE;
      presc  <= '0;
      ms_cnt <= '0;
    end else if (press_edge) begin
      state  <= RPT_DELAY;
      presc  <= '0;
      ms_cnt <= '0;
    end else begin
      case (state)
        RPT_DELAY, RPT_REPEAT: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (rpt_fire) begin
              state  <= RPT_REPEAT;
              ms_cnt <= '0;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= RPT_IDLE;
          presc  <= '0;
          ms_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock_14Mhz) begin
    if (reset) begin
      strobe    <= 1'b0;
      kbd_ascii <= '0;
    end else if (pop) begin
      strobe    <= 1'b1;
      kbd_ascii <= fifo_dout;
    end else if (clear_strobe) begin
      strobe    <= 1'b0;
    end
  end

  // A push into a full FIFO is lost even when a pop frees a slot in the same cycle.
  always_ff @(posedge Clock_14Mhz) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  assign kbd_data = {strobe, 7'(kbd_ascii)};

endmodule

// File: tb/tb_key_buffer.sv
// Directed bench for key_buffer with short repeat timing and a 4-entry FIFO.
module tb_key_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_down = 1'b0;
  logic [6:0] ascii_in = 7'h00;
  logic       clear_strobe = 1'b0;
  logic [7:0] kbd_data;
  logic       any_key_down;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  key_buffer #(
    .DEPTH         (4),
    .DATA_W        (7),
    .TICK_DIV      (4),
    .REPEAT_DELAY  (5),
    .REPEAT_PERIOD (2)
  ) dut (
    .Clock_14Mhz  (clk),
    .reset        (reset),
    .key_down     (key_down),
    .ascii_in     (ascii_in),
    .clear_strobe (clear_strobe),
    .kbd_data     (kbd_data),
    .any_key_down (any_key_down),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [6:0] code);
    key_down = 1'b1;
    ascii_in = code;
    step(1);
    key_down = 1'b0;
    step(1);
  endtask

  task automatic clear_and_load;
    clear_strobe = 1'b1;
    step(1);
    clear_strobe = 1'b0;
    step(1);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    key_down = 1'b0;
    clear_strobe = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    key_down = 1'b1;
    ascii_in = 7'h55;
    clear_strobe = 1'b1;
    step(3);
    n_cmp++; if (kbd_data !== 8'h00) begin n_bad++; $display("FAIL reset_kbd: got %h want 00", kbd_data); end
    n_cmp++; if (any_key_down !== 1'b0) begin n_bad++; $display("FAIL reset_any: got %b want 0", any_key_down); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    reset = 1'b0;
    key_down = 1'b0;
    clear_strobe = 1'b0;
    step(2);
    n_cmp++; if (kbd_data !== 8'h00) begin n_bad++; $display("FAIL reset_idle_kbd: got %h want 00", kbd_data); end
  endtask

  task automatic test_single_key;
    key_down = 1'b1;
    ascii_in = 7'h41;
    step(1);
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_count_t1: got %0d want 1", fifo_count); end
    n_cmp++; if (kbd_data !== 8'h00) begin n_bad++; $display("FAIL single_kbd_t1: got %h want 00", kbd_data); end
    n_cmp++; if (any_key_down !== 1'b1) begin n_bad++; $display("FAIL single_any: got %b want 1", any_key_down); end
    step(1);
    n_cmp++; if (kbd_data !== 8'hC1) begin n_bad++; $display("FAIL single_kbd_t2: got %h want C1", kbd_data); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL single_count_t2: got %0d want 0", fifo_count); end
    key_down = 1'b0;
    step(8);
    clear_strobe = 1'b1;
    step(1);
    clear_strobe = 1'b0;
    n_cmp++; if (kbd_data !== 8'h41) begin n_bad++; $display("FAIL single_clear: got %h want 41", kbd_data); end
    step(1);
    n_cmp++; if (kbd_data !== 8'h41) begin n_bad++; $display("FAIL single_hold: got %h want 41", kbd_data); end
    clear_strobe = 1'b1;
    step(1);
    clear_strobe = 1'b0;
    n_cmp++; if (kbd_data !== 8'h41) begin n_bad++; $display("FAIL single_clear_idle: got %h want 41", kbd_data); end
  endtask

  task automatic test_queueing;
    press(7'h41);
    press(7'h42);
    press(7'h43);
    n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL queue_count: got %0d want 2", fifo_count); end
    n_cmp++; if (kbd_data !== 8'hC1) begin n_bad++; $display("FAIL queue_head: got %h want C1", kbd_data); end
    clear_strobe = 1'b1;
    step(1);
    clear_strobe = 1'b0;
    n_cmp++; if (kbd_data !== 8'h41) begin n_bad++; $display("FAIL queue_gap: got %h want 41", kbd_data); end
    step(1);
    n_cmp++; if (kbd_data !== 8'hC2) begin n_bad++; $display("FAIL queue_b: got %h want C2", kbd_data); end
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL queue_count_b: got %0d want 1", fifo_count); end
    clear_and_load;
    n_cmp++; if (kbd_data !== 8'hC3) begin n_bad++; $display("FAIL queue_c: got %h want C3", kbd_data); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL queue_count_c: got %0d want 0", fifo_count); end
  endtask

  task automatic test_overflow;
    logic [7:0] want;
    do_reset;
    for (int i = 1; i <= 6; i++) press(7'(8'h30 + i));
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (kbd_data !== 8'hB1) begin n_bad++; $display("FAIL ovf_head: got %h want B1", kbd_data); end
    for (int i = 2; i <= 5; i++) begin
      clear_and_load;
      want = 8'hB0 + 8'(i);
      n_cmp++; if (kbd_data !== want) begin n_bad++; $display("FAIL ovf_drain_%0d: got %h want %h", i, kbd_data, want); end
      n_cmp++; if (fifo_count !== 3'(5 - i)) begin n_bad++; $display("FAIL ovf_drain_count_%0d: got %0d want %0d", i, fifo_count, 5 - i); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_simultaneous;
    logic [7:0] want;
    do_reset;
    for (int i = 1; i <= 5; i++) press(7'(8'h60 + i));
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL sim_fill: got %0d want 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sim_no_ovf: got %b want 0", overflow); end
    clear_strobe = 1'b1;
    key_down = 1'b1;
    ascii_in = 7'h66;
    step(1);
    n_cmp++; if (kbd_data !== 8'h61) begin n_bad++; $display("FAIL sim_clear: got %h want 61", kbd_data); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL sim_ovf: got %b want 1", overflow); end
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL sim_count_full: got %0d want 4", fifo_count); end
    clear_strobe = 1'b0;
    ascii_in = 7'h67;
    step(1);
    key_down = 1'b0;
    n_cmp++; if (kbd_data !== 8'hE2) begin n_bad++; $display("FAIL sim_pop: got %h want E2", kbd_data); end
    n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL sim_count_pop: got %0d want 3", fifo_count); end
    for (int i = 3; i <= 5; i++) begin
      clear_and_load;
      want = 8'hE0 + 8'(i);
      n_cmp++; if (kbd_data !== want) begin n_bad++; $display("FAIL sim_order_%0d: got %h want %h", i, kbd_data, want); end
    end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL sim_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_auto_repeat;
    do_reset;
    key_down = 1'b1;
    ascii_in = 7'h20;
    step(1);
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL rpt_press: got %0d want 1", fifo_count); end
    step(1);
    n_cmp++; if (kbd_data !== 8'hA0) begin n_bad++; $display("FAIL rpt_present: got %h want A0", kbd_data); end
    step(18);
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rpt_early: got %0d want 0", fifo_count); end
    step(1);
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL rpt_first: got %0d want 1", fifo_count); end
    step(7);
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL rpt_period_early: got %0d want 1", fifo_count); end
    step(1);
    n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL rpt_second: got %0d want 2", fifo_count); end
    key_down = 1'b0;
    step(30);
    n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL rpt_release: got %0d want 2", fifo_count); end
  endtask

  task automatic test_reset_mid_repeat;
    do_reset;
    key_down = 1'b1;
    ascii_in = 7'h20;
    step(37);
    n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL mid_queued: got %0d want 3", fifo_count); end
    reset = 1'b1;
    key_down = 1'b0;
    step(1);
    n_cmp++; if (kbd_data !== 8'h00) begin n_bad++; $display("FAIL mid_kbd: got %h want 00", kbd_data); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
    n_cmp++; if (any_key_down !== 1'b0) begin n_bad++; $display("FAIL mid_any: got %b want 0", any_key_down); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_ovf: got %b want 0", overflow); end
    reset = 1'b0;
    step(40);
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_no_push_count: got %0d want 0", fifo_count); end
    n_cmp++; if (kbd_data !== 8'h00) begin n_bad++; $display("FAIL mid_no_push_kbd: got %h want 00", kbd_data); end
    press(7'h52);
    n_cmp++; if (kbd_data !== 8'hD2) begin n_bad++; $display("FAIL mid_new_press: got %h want D2", kbd_data); end
  endtask

  initial begin
    test_reset;
    test_single_key;
    test_queueing;
    test_overflow;
    test_simultaneous;
    test_auto_repeat;
    test_reset_mid_repeat;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
